// File: rtl/conv_stream_checker.sv
// conv_stream_checker
// Sink for the convolution accelerator output stream. Drives the ready side
// of the handshake, compares every accepted word against a preloaded
// expected-value memory, and reports transfer count, error count and the
// first mismatch seen in the run.
//
// Optional feature macro: CONV_CHK_BACKPRESSURE_EN
//   defined   -> s_ready in RUN follows bit 0 of a 16-bit Fibonacci LFSR
//   undefined -> s_ready is held high for every RUN cycle (no LFSR)
module conv_stream_checker #(
  parameter int          WIDTH     = 16,
  parameter int          NUMOUT    = 32,
  parameter int          LOGN      = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] s_data_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             exp_wr_en,
  input  logic [LOGN-1:0]  exp_wr_addr,
  input  logic [WIDTH-1:0] exp_wr_data,
  output logic [LOGN:0]    count,
  output logic [15:0]      errors,
  output logic             first_err_valid,
  output logic [LOGN-1:0]  first_err_idx,
  output logic [WIDTH-1:0] first_err_data,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_mem [NUMOUT];
  logic [WIDTH-1:0] r_exp_q;
  logic [LOGN-1:0]  r_idx;
  logic [LOGN-1:0]  w_idx_nxt;

  logic [LOGN:0]    r_count;
  logic [15:0]      r_errors;
  logic             r_first_err_valid;
  logic [LOGN-1:0]  r_first_err_idx;
  logic [WIDTH-1:0] r_first_err_data;
  logic             r_done;

  logic w_ready;
  logic w_xfer;
  logic w_last;
  logic w_start_run;
  logic w_wr_ok;
  logic w_mismatch;

  // Start is honoured only outside RUN; the last index ends the run.
  assign w_start_run = start && (r_state != ST_RUN);
  assign w_xfer      = s_valid && w_ready;
  assign w_last      = (r_idx == LOGN'(NUMOUT - 1));
  assign w_wr_ok     = exp_wr_en && !start && (r_state != ST_RUN) &&
                       (int'(exp_wr_addr) < NUMOUT);
  // Case inequality so that X/Z on the stream is flagged in simulation.
  assign w_mismatch  = (s_data_in !== r_exp_q);

`ifdef CONV_CHK_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_ready   = (r_state == ST_RUN) && r_lfsr[0];

  // LFSR advances once per RUN cycle; only reset reseeds it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (r_state == ST_RUN) begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end else begin
      r_lfsr <= r_lfsr;
    end
  end
`else
  logic w_unused_seed;

  assign w_unused_seed = ^LFSR_SEED;
  assign w_ready       = (r_state == ST_RUN);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE/DONE -> RUN on start, RUN -> DONE on final transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_xfer && w_last) w_state_nxt = ST_DONE;
        else                  w_state_nxt = ST_RUN;
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next-cycle index; wraps to 0 after the last word so the read stays in range.
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_start_run) begin
      w_idx_nxt = '0;
    end else if (w_xfer) begin
      if (w_last) w_idx_nxt = '0;
      else        w_idx_nxt = r_idx + LOGN'(1);
    end else begin
      w_idx_nxt = r_idx;
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  // Expected memory: no reset so contents survive a reset between runs.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[exp_wr_addr] <= exp_wr_data;
    end
  end

  // Synchronous read addressed by the next index so r_exp_q matches r_idx.
  always_ff @(posedge clk) begin
    r_exp_q <= r_mem[w_idx_nxt];
  end

  // Run status: cleared by start, updated on every accepted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count           <= '0;
      r_errors          <= 16'd0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
      r_first_err_data  <= '0;
      r_done            <= 1'b0;
    end else if (w_start_run) begin
      r_count           <= '0;
      r_errors          <= 16'd0;
      r_first_err_valid <= 1'b0;
      r_first_err_idx   <= '0;
      r_first_err_data  <= '0;
      r_done            <= 1'b0;
    end else if (w_xfer) begin
      r_count <= r_count + (LOGN+1)'(1);
      if (w_mismatch) begin
        if (r_errors != 16'hFFFF) r_errors <= r_errors + 16'd1;
        if (!r_first_err_valid) begin
          r_first_err_valid <= 1'b1;
          r_first_err_idx   <= r_idx;
          r_first_err_data  <= s_data_in;
        end
      end
      if (w_last) r_done <= 1'b1;
    end
  end

  assign s_ready         = w_ready;
  assign count           = r_count;
  assign errors          = r_errors;
  assign first_err_valid = r_first_err_valid;
  assign first_err_idx   = r_first_err_idx;
  assign first_err_data  = r_first_err_data;
  assign done            = r_done;

endmodule

// File: tb/tb_conv_stream_checker.sv
// Directed testbench for conv_stream_checker (default parameters).
module tb_conv_stream_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] s_data_in;
  logic        s_valid;
  logic        s_ready;
  logic        exp_wr_en;
  logic [4:0]  exp_wr_addr;
  logic [15:0] exp_wr_data;
  logic [5:0]  count;
  logic [15:0] errors;
  logic        first_err_valid;
  logic [4:0]  first_err_idx;
  logic [15:0] first_err_data;
  logic        done;

  int          checks = 0;
  int          failures = 0;
  int          run_cycles;
  logic [15:0] m_lfsr;

  conv_stream_checker dut (
    .clk(clk), .reset(reset), .start(start),
    .s_data_in(s_data_in), .s_valid(s_valid), .s_ready(s_ready),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
    .count(count), .errors(errors), .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx), .first_err_data(first_err_data), .done(done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  function automatic logic [15:0] word_for(input int w, input int bad1,
                                            input logic [15:0] bad1_val, input int bad2);
    logic [15:0] v;
    v = 16'(3 * w);
    if (w == bad1)      v = bad1_val;
    else if (w == bad2) v = v ^ 16'h00FF;
    return v;
  endfunction

  task automatic do_start(input logic wr_too);
    @(negedge clk);
    start = 1'b1;
    exp_wr_en = wr_too;
    exp_wr_addr = 5'd3;
    exp_wr_data = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    exp_wr_en = 1'b0;
  endtask

  // Streams words until stop_at have been accepted; runs entirely on negedges.
  task automatic stream(input int stop_at, input int bad1, input logic [15:0] bad1_val,
                        input int bad2, input int gap_after, input int gap_len,
                        input int pulse_at);
    int   w;
    int   gap_left;
    logic exp_rdy;
    logic acc;
    bit   pulsed;
    w = 0; gap_left = 0; run_cycles = 0; pulsed = 0;
    while (w < stop_at && run_cycles < 400) begin
`ifdef CONV_CHK_BACKPRESSURE_EN
      exp_rdy = m_lfsr[0];
`else
      exp_rdy = 1'b1;
`endif
      checks++;
      if (s_ready !== exp_rdy) begin
        failures++;
        $display("FAIL s_ready cyc%0d: got %b expected %b", run_cycles, s_ready, exp_rdy);
      end
      start = 1'b0;
      exp_wr_en = 1'b0;
      if (w == pulse_at && !pulsed) begin
        start = 1'b1;
        exp_wr_en = 1'b1;
        exp_wr_addr = 5'd20;
        exp_wr_data = 16'hDEAD;
        pulsed = 1;
      end
      if (gap_left > 0) begin
        s_valid = 1'b0;
        gap_left--;
        checks++;
        if (count !== 6'(gap_after + 1) || errors !== 16'd0) begin
          failures++;
          $display("FAIL gap_hold: count=%0d errors=%0d expected count=%0d errors=0",
                   count, errors, gap_after + 1);
        end
      end else begin
        s_valid = 1'b1;
        s_data_in = word_for(w, bad1, bad1_val, bad2);
      end
      acc = s_valid && exp_rdy;
      @(posedge clk);
`ifdef CONV_CHK_BACKPRESSURE_EN
      m_lfsr = lfsr_step(m_lfsr);
`endif
      run_cycles++;
      if (acc) begin
        w++;
        if (gap_len > 0 && w == gap_after + 1) gap_left = gap_len;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    start = 1'b0;
    exp_wr_en = 1'b0;
    checks++;
    if (w < stop_at) begin
      failures++;
      $display("FAIL stream_timeout: accepted %0d expected %0d", w, stop_at);
    end
  endtask

  task automatic check_end(input string name, input logic [15:0] exp_err,
                           input logic exp_fev, input logic [4:0] exp_fei,
                           input logic [15:0] exp_fed);
    checks++;
    if (done !== 1'b1 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_done: done=%b s_ready=%b expected done=1 s_ready=0", name, done, s_ready);
    end
    checks++;
    if (count !== 6'd32) begin
      failures++;
      $display("FAIL %s_count: got %0d expected 32", name, count);
    end
    checks++;
    if (errors !== exp_err || first_err_valid !== exp_fev) begin
      failures++;
      $display("FAIL %s_errors: errors=%0d fev=%b expected %0d/%b",
               name, errors, first_err_valid, exp_err, exp_fev);
    end
    if (exp_fev) begin
      checks++;
      if (first_err_idx !== exp_fei || first_err_data !== exp_fed) begin
        failures++;
        $display("FAIL %s_first: idx=%0d data=%h expected %0d/%h",
                 name, first_err_idx, first_err_data, exp_fei, exp_fed);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data_in = 16'd0;
    exp_wr_en = 1'b0; exp_wr_addr = 5'd0; exp_wr_data = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_lfsr = 16'hACE1;
    checks++;
    if (s_ready !== 1'b0 || count !== 6'd0 || errors !== 16'd0 || done !== 1'b0 ||
        first_err_valid !== 1'b0 || first_err_idx !== 5'd0 || first_err_data !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b cnt=%0d err=%0d done=%b fev=%b fei=%0d fed=%h expected all 0",
               s_ready, count, errors, done, first_err_valid, first_err_idx, first_err_data);
    end
    // Load exp[i] = 3*i while idle.
    for (int i = 0; i < 32; i++) begin
      exp_wr_en = 1'b1;
      exp_wr_addr = 5'(i);
      exp_wr_data = 16'(3 * i);
      @(posedge clk);
      @(negedge clk);
    end
    exp_wr_en = 1'b0;
  endtask

  task automatic test_clean_run();
    do_start(1'b0);
    stream(32, -1, 16'd0, -1, -1, 0, -1);
    check_end("clean", 16'd0, 1'b0, 5'd0, 16'd0);
`ifndef CONV_CHK_BACKPRESSURE_EN
    checks++;
    if (run_cycles != 32) begin
      failures++;
      $display("FAIL clean_run_cycles: got %0d expected 32", run_cycles);
    end
`endif
  endtask

  task automatic test_errors();
    do_start(1'b0);
    stream(32, 5, 16'h0BAD, 9, -1, 0, -1);
    check_end("errors", 16'd2, 1'b1, 5'd5, 16'h0BAD);
  endtask

  task automatic test_done_restart();
    // Start in DONE with a write strobe that must be ignored (start high).
    do_start(1'b1);
    checks++;
    if (errors !== 16'd0 || first_err_valid !== 1'b0 || done !== 1'b0 || count !== 6'd0 ||
        first_err_idx !== 5'd0 || first_err_data !== 16'd0) begin
      failures++;
      $display("FAIL restart_clear: err=%0d fev=%b done=%b cnt=%0d expected 0",
               errors, first_err_valid, done, count);
    end
    stream(32, -1, 16'd0, -1, -1, 0, -1);
    check_end("restart", 16'd0, 1'b0, 5'd0, 16'd0);
  endtask

  task automatic test_gap();
    do_start(1'b0);
    stream(32, -1, 16'd0, -1, 12, 10, -1);
    check_end("gap", 16'd0, 1'b0, 5'd0, 16'd0);
  endtask

  task automatic test_start_in_run();
    do_start(1'b0);
    stream(32, -1, 16'd0, -1, -1, 0, 4);
    check_end("start_in_run", 16'd0, 1'b0, 5'd0, 16'd0);
  endtask

  task automatic test_reset_mid();
    do_start(1'b0);
    stream(10, -1, 16'd0, -1, -1, 0, -1);
    checks++;
    if (count !== 6'd10) begin
      failures++;
      $display("FAIL mid_count: got %0d expected 10", count);
    end
    s_valid = 1'b1;
    s_data_in = 16'd30;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0 || count !== 6'd0 || errors !== 16'd0 || done !== 1'b0 ||
        first_err_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: rdy=%b cnt=%0d err=%0d done=%b fev=%b expected all 0",
               s_ready, count, errors, done, first_err_valid);
    end
    reset = 1'b0;
    s_valid = 1'b0;
    m_lfsr = 16'hACE1;
    do_start(1'b0);
    stream(32, -1, 16'd0, -1, -1, 0, -1);
    check_end("after_reset", 16'd0, 1'b0, 5'd0, 16'd0);
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_clean_run();
    test_errors();
    test_done_restart();
    test_gap();
    test_start_in_run();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_stream_checker.md
# conv_stream_checker

Synthesizable sink for the convolution accelerator's output stream (`m_data_out_y` / `m_valid_y` / `m_ready_y`). It drives the ready side of the handshake and can apply pseudo-random backpressure. Each accepted word is compared against an expected-value memory loaded beforehand, and the block reports transfer count, error count and the first mismatch. It sits on-chip or in FPGA bring-up in place of the bench consumer, attached directly to a `conv_*` top.

## Interface
- `WIDTH`, 16, data word width (matches conv `WIDTH`)
- `NUMOUT`, 32, outputs expected per run (≥1)
- `LOGN`, 5, index width; 2**LOGN ≥ NUMOUT
- `LFSR_SEED`, 16'hACE1, nonzero backpressure LFSR seed

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a run (sampled in IDLE/DONE only)
- `s_data_in`  in  WIDTH  stream data (from conv `m_data_out_y`)
- `s_valid`  in  1  stream valid (from conv `m_valid_y`)
- `s_ready`  out  1  stream ready (to conv `m_ready_y`)
- `exp_wr_en`  in  1  expected-memory write strobe
- `exp_wr_addr`  in  LOGN  expected-memory write address
- `exp_wr_data`  in  WIDTH  expected value
- `count`  out  LOGN+1  transfers accepted this run
- `errors`  out  16  mismatches this run, saturating at 16'hFFFF
- `first_err_valid`  out  1  a mismatch has been recorded
- `first_err_idx`  out  LOGN  index of first mismatch
- `first_err_data`  out  WIDTH  received data at first mismatch
- `done`  out  1  run complete

## Operation
- States: IDLE → RUN (on `start`) → DONE (on final transfer) → RUN (on `start`).
- Reset values: state IDLE, `s_ready` 0, `count` 0, `errors` 0, `first_err_valid` 0, `first_err_idx` 0, `first_err_data` 0, `done` 0, LFSR = `LFSR_SEED`.
- Expected memory: NUMOUT×WIDTH, no reset, contents survive `reset`.
- Writes are accepted only in IDLE/DONE with `start` low. They are ignored in RUN and when `start` is high.
- Read is synchronous, one cycle. Read address = next-cycle index, so registered `exp_q` always holds `exp[idx]` for the current `idx`.
- `start` in IDLE/DONE: clears `count`, `errors`, `first_err_*` and `done`; sets `idx` = 0; goes to RUN. `start` in RUN is ignored.
- Transfer = `s_valid && s_ready` at posedge. On a transfer:
  - `count`++ and `idx`++.
  - If `s_data_in !== exp_q`: `errors`++ (saturating). If `first_err_valid` = 0, latch `idx` and `s_data_in` and set `first_err_valid`.
- A transfer at `idx` = NUMOUT−1 moves to DONE and sets `done` = 1. `done` holds until the next `start` or `reset`.
- `s_ready` is a function of state and LFSR registers only. It never depends combinationally on `s_valid`. It is 0 outside RUN.
- Comparison is bitwise on the full WIDTH. X/Z on `s_data_in` during a transfer counts as a mismatch in simulation.
- `reset` mid-run returns to IDLE immediately. Any in-flight handshake in that cycle is not counted.

## Timing
- `s_ready` is high in the first RUN cycle after `start`, subject to the LFSR.
- Status outputs (`count`, `errors`, `first_err_*`) update on the clock edge of the transfer and are visible in the following cycle.
- `done` rises in the cycle after the final transfer. `s_ready` is 0 in that same cycle.
- Minimum run length without backpressure: NUMOUT cycles of RUN for NUMOUT back-to-back transfers.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances once per RUN cycle regardless of `s_valid` and holds in IDLE/DONE. `start` does not reseed it; only `reset` does.

## Configuration
- `CONV_CHK_BACKPRESSURE_EN` defined: in RUN, `s_ready` = `lfsr[0]`.
- `CONV_CHK_BACKPRESSURE_EN` undefined: in RUN, `s_ready` = 1 every cycle. The LFSR logic is removed.
- No other behaviour differs between the two builds.

## Test plan
- Load `exp[i]` = 3·i for i = 0..31, pulse `start`, stream matching data with `s_valid` held high → `done` after 32 transfers, `count` = 32, `errors` = 0, `first_err_valid` = 0.
- Same load; corrupt words 5 (send 16'h0BAD) and 9 → `errors` = 2, `first_err_idx` = 5, `first_err_data` = 16'h0BAD.
- Drop `s_valid` low for 10 cycles after word 12 → `count` stays 13, no error increments, and the run completes with `errors` = 0.
- Assert `reset` at `idx` = 10 → `s_ready` = 0 and all counters 0 in the next cycle, state IDLE. Then pulse `start` without reloading → the run checks from `idx` 0 against the retained memory and passes.
- With the macro defined: `s_ready` toggles per the seed-16'hACE1 LFSR sequence and the run still completes with 32 transfers and 0 errors. Without the macro: 32 transfers in exactly 32 RUN cycles.
- Pulse `start` during RUN → ignored, `count` unaffected. Pulse `start` in DONE after an errored run → `errors` and `first_err_valid` clear and a new run begins. An `exp_wr_en` issued during RUN does not alter memory.
